// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit with MTHI/MTLO writes.
// Define MDU_DIV_EN to build the DIV/DIVU datapath; otherwise those opcodes are ignored.
module mult_div_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
    localparam int unsigned PW      = 2 * WIDTH;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;
    logic             busy_nxt, done_nxt;
    logic             load, load_div;
    logic [WIDTH-1:0] a_q, b_q;
    logic             sgn_q, div_q;

    // Multiplier: sign- or zero-extend, low 2*WIDTH bits are the exact product
    logic [PW-1:0] ext_a, ext_b, prod;

    assign ext_a = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign ext_b = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign prod  = ext_a * ext_b;

`ifdef MDU_DIV_EN
    // Divider on magnitudes; quotient truncates toward zero, remainder follows dividend
    logic             neg_a, neg_b, div_zero;
    logic [WIDTH-1:0] mag_a, mag_b, quo, rem, quo_s, rem_s;

    assign neg_a    = sgn_q & a_q[WIDTH-1];
    assign neg_b    = sgn_q & b_q[WIDTH-1];
    assign mag_a    = neg_a ? -a_q : a_q;
    assign mag_b    = neg_b ? -b_q : b_q;
    assign div_zero = (b_q == '0);
    assign quo      = mag_a / (div_zero ? WIDTH'(1) : mag_b);
    assign rem      = mag_a % (div_zero ? WIDTH'(1) : mag_b);
    assign quo_s    = (neg_a ^ neg_b) ? -quo : quo;
    assign rem_s    = neg_a ? -rem : rem;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
            div_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            if (load) begin
                a_q   <= a;
                b_q   <= b;
                sgn_q <= ~op[0];
                div_q <= load_div;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        hi_nxt    = hi;
        lo_nxt    = lo;
        load      = 1'b0;
        load_div  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            load      = 1'b1;
                            cnt_nxt   = CNT_W'(MUL_LAT);
                            state_nxt = RUN;
                            busy_nxt  = 1'b1;
                        end
`ifdef MDU_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            load      = 1'b1;
                            load_div  = 1'b1;
                            cnt_nxt   = CNT_W'(DIV_LAT);
                            state_nxt = RUN;
                            busy_nxt  = 1'b1;
                        end
`endif
                        OP_MTHI: hi_nxt = a;
                        OP_MTLO: lo_nxt = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Results land only on the final cycle; start is ignored meanwhile
                if (cnt <= CNT_W'(1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    if (div_q) begin
`ifdef MDU_DIV_EN
                        if (!div_zero) begin
                            hi_nxt = rem_s;
                            lo_nxt = quo_s;
                        end
`endif
                    end else begin
                        hi_nxt = prod[PW-1:WIDTH];
                        lo_nxt = prod[WIDTH-1:0];
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
